// File: rtl/atomik_edge_sensor_imu_delta_encoder.sv
// IMU delta encoder: turns a sample stream into LOAD / XOR-ACCUMULATE strobes
// for a downstream fusion accumulator, with periodic resync and zero-delta suppression.
module atomik_edge_sensor_imu_delta_encoder #(
  parameter int DATA_WIDTH      = 64,
  parameter int RESYNC_INTERVAL = 1024,
  parameter bit SUPPRESS_ZERO   = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sample_valid,
  output logic                               sample_ready,
  input  logic [DATA_WIDTH-1:0]              sample_data,
  input  logic                               flush,
  output logic                               load_en,
  output logic                               accumulate_en,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic [$clog2(RESYNC_INTERVAL):0]   delta_count,
  output logic [15:0]                        suppressed_count
);

  localparam int CW = $clog2(RESYNC_INTERVAL) + 1;
  localparam logic [CW-1:0] RESYNC_MAX = CW'(RESYNC_INTERVAL);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_EMPTY  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] prev, prev_nxt, data_nxt, delta;
  logic [CW-1:0]         cnt_nxt;
  logic [15:0]           supp_nxt;
  logic                  flush_pending, pend_nxt;
  logic                  load_nxt, acc_nxt, accept;

  assign accept = sample_valid && sample_ready;
  assign delta  = sample_data ^ prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:   state_nxt = ST_EMPTY;
      ST_EMPTY:  state_nxt = accept ? ST_STREAM : ST_EMPTY;
      ST_STREAM: state_nxt = ST_STREAM;
      default:   state_nxt = ST_INIT;
    endcase
  end

  // Next values of every registered output; a same-cycle flush forces a LOAD.
  always_comb begin
    load_nxt = 1'b0;
    acc_nxt  = 1'b0;
    data_nxt = data_out;
    prev_nxt = prev;
    cnt_nxt  = delta_count;
    supp_nxt = suppressed_count;
    pend_nxt = flush_pending | flush;
    if (accept) begin
      prev_nxt = sample_data;
      case (state)
        ST_EMPTY: begin
          load_nxt = 1'b1;
          data_nxt = sample_data;
          cnt_nxt  = {CW{1'b0}};
          pend_nxt = 1'b0;
        end
        ST_STREAM: begin
          if (flush_pending || flush || (delta_count == RESYNC_MAX)) begin
            load_nxt = 1'b1;
            data_nxt = sample_data;
            cnt_nxt  = {CW{1'b0}};
            pend_nxt = 1'b0;
          end else if ((delta == {DATA_WIDTH{1'b0}}) && (SUPPRESS_ZERO == 1'b1)) begin
            if (suppressed_count != 16'hFFFF) begin
              supp_nxt = suppressed_count + 16'd1;
            end else begin
              supp_nxt = suppressed_count;
            end
          end else begin
            acc_nxt  = 1'b1;
            data_nxt = delta;
            cnt_nxt  = delta_count + CW'(1);
          end
        end
        default: begin
          load_nxt = 1'b0;
        end
      endcase
    end else begin
      prev_nxt = prev;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_ready     <= 1'b0;
      load_en          <= 1'b0;
      accumulate_en    <= 1'b0;
      data_out         <= {DATA_WIDTH{1'b0}};
      prev             <= {DATA_WIDTH{1'b0}};
      delta_count      <= {CW{1'b0}};
      suppressed_count <= 16'd0;
      flush_pending    <= 1'b0;
    end else begin
      sample_ready     <= (state_nxt != ST_INIT);
      load_en          <= load_nxt;
      accumulate_en    <= acc_nxt;
      data_out         <= data_nxt;
      prev             <= prev_nxt;
      delta_count      <= cnt_nxt;
      suppressed_count <= supp_nxt;
      flush_pending    <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_atomik_edge_sensor_imu_delta_encoder.sv
// Directed bench for the IMU delta encoder (RESYNC_INTERVAL=4) with a short
// pseudo-random tail checked against a downstream fusion accumulator model.
module tb_atomik_edge_sensor_imu_delta_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic        sample_ready;
  logic [63:0] sample_data;
  logic        flush;
  logic        load_en;
  logic        accumulate_en;
  logic [63:0] data_out;
  logic [2:0]  delta_count;
  logic [15:0] suppressed_count;

  int vectors = 0;
  int miscompares = 0;

  atomik_edge_sensor_imu_delta_encoder #(
    .DATA_WIDTH(64), .RESYNC_INTERVAL(4), .SUPPRESS_ZERO(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_data(sample_data), .flush(flush), .load_en(load_en),
    .accumulate_en(accumulate_en), .data_out(data_out), .delta_count(delta_count),
    .suppressed_count(suppressed_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ld, input logic ac,
                         input logic [63:0] d, input logic [2:0] cnt);
    chk({tag, ".load"}, 64'(load_en), 64'(ld));
    chk({tag, ".acc"}, 64'(accumulate_en), 64'(ac));
    chk({tag, ".data"}, data_out, d);
    chk({tag, ".cnt"}, 64'(delta_count), 64'(cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] fused, last, smp;
    logic        took;

    rst = 1'b1; sample_valid = 1'b1; sample_data = 64'hA5; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 64'(sample_ready), 64'd0);
    chk_out("rst", 1'b0, 1'b0, 64'd0, 3'd0);
    chk("rst.supp", 64'(suppressed_count), 64'd0);

    rst = 1'b0;
    #1 chk("init.ready", 64'(sample_ready), 64'd0);
    tick();
    chk("empty.ready", 64'(sample_ready), 64'd1);
    chk_out("empty", 1'b0, 1'b0, 64'd0, 3'd0);
    tick();
    chk_out("load_a5", 1'b1, 1'b0, 64'hA5, 3'd0);

    sample_data = 64'hF0; tick();
    chk_out("acc_55", 1'b0, 1'b1, 64'h55, 3'd1);
    tick();
    chk_out("supp", 1'b0, 1'b0, 64'h55, 3'd1);
    chk("supp.count", 64'(suppressed_count), 64'd1);
    sample_data = 64'h0F; tick();
    chk_out("acc_ff", 1'b0, 1'b1, 64'hFF, 3'd2);
    sample_data = 64'h11; tick();
    chk_out("acc_1e", 1'b0, 1'b1, 64'h1E, 3'd3);
    sample_data = 64'h22; tick();
    chk_out("acc_33", 1'b0, 1'b1, 64'h33, 3'd4);
    sample_data = 64'h44; tick();
    chk_out("resync", 1'b1, 1'b0, 64'h44, 3'd0);

    sample_valid = 1'b0; tick();
    chk_out("idle", 1'b0, 1'b0, 64'h44, 3'd0);
    flush = 1'b1; tick();
    flush = 1'b0;
    chk_out("flush_alone", 1'b0, 1'b0, 64'h44, 3'd0);
    tick();
    sample_valid = 1'b1; sample_data = 64'h1234; tick();
    chk_out("flush_load", 1'b1, 1'b0, 64'h1234, 3'd0);
    sample_data = 64'h1235; tick();
    chk_out("post_flush", 1'b0, 1'b1, 64'h1, 3'd1);
    flush = 1'b1; sample_data = 64'h5678; tick();
    flush = 1'b0;
    chk_out("flush_same", 1'b1, 1'b0, 64'h5678, 3'd0);
    sample_data = 64'h5679; tick();
    chk_out("flush_clr", 1'b0, 1'b1, 64'h1, 3'd1);

    sample_data = 64'h9999;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst.ready", 64'(sample_ready), 64'd0);
    chk_out("mid_rst", 1'b0, 1'b0, 64'd0, 3'd0);
    chk("mid_rst.supp", 64'(suppressed_count), 64'd0);
    tick();
    rst = 1'b0; flush = 1'b1; sample_data = 64'hAAAA;
    #1 chk("init2.ready", 64'(sample_ready), 64'd0);
    tick();
    flush = 1'b0;
    chk_out("init_flush", 1'b0, 1'b0, 64'd0, 3'd0);
    tick();
    chk_out("post_rst_load", 1'b1, 1'b0, 64'hAAAA, 3'd0);
    sample_data = 64'hAAAB; tick();
    chk_out("pend_cleared", 1'b0, 1'b1, 64'h1, 3'd1);

    // Small values make zero deltas and resyncs frequent.
    fused = 64'hAAAB;
    last  = 64'hAAAB;
    for (int i = 0; i < 40; i++) begin
      sample_valid = ($urandom_range(0, 3) != 0);
      sample_data  = 64'($urandom_range(0, 3));
      flush        = ($urandom_range(0, 7) == 0);
      took = sample_valid && sample_ready;
      smp  = sample_data;
      tick();
      if (load_en) fused = data_out;
      else if (accumulate_en) fused = fused ^ data_out;
      if (took) last = smp;
      chk("fusion", fused, last);
      chk("excl", 64'(load_en & accumulate_en), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
